// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC receive deframer: FSM states, flag octet and
// run-length thresholds used by the zero destuffer.
package hdlc_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    OPEN = 2'd1,
    DATA = 2'd2
  } hdlc_state_e;

  localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
  localparam int unsigned ONES_STUFF = 5;
  localparam int unsigned ONES_FLAG  = 6;
  localparam int unsigned ONES_W     = 3;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned BYTE_W     = 8;

  // Bit count left in sr when an aligned closing flag arrives: its leading 0 and five 1s.
  localparam int unsigned FLAG_TAIL_BITS = ONES_STUFF + 1;

endpackage

// File: rtl/hdlc_zero_destuffer.sv
// Classifies each line bit as flag, abort, dropped (stuffed/6th one) or data,
// tracking the run of consecutive 1s.
module hdlc_zero_destuffer
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic flag_in,
  output logic data_bit_vld,
  output logic data_bit,
  output logic flag_evt,
  output logic abort_evt
);

  logic [ONES_W-1:0] r_ones_cnt;
  logic [ONES_W-1:0] w_ones_nxt;

  // Priority-ordered classification of the current bit
  always_comb begin
    data_bit_vld = 1'b0;
    data_bit     = bit_in;
    flag_evt     = 1'b0;
    abort_evt    = 1'b0;
    w_ones_nxt   = bit_in ? (r_ones_cnt + ONES_W'(1)) : '0;
    if (flag_in) begin
      flag_evt   = 1'b1;
      w_ones_nxt = '0;
    end else if (r_ones_cnt == ONES_W'(ONES_FLAG)) begin
      abort_evt  = 1'b1;
      w_ones_nxt = bit_in ? ONES_W'(ONES_FLAG) : '0;
    end else if (r_ones_cnt == ONES_W'(ONES_STUFF)) begin
      data_bit_vld = 1'b0;
    end else begin
      data_bit_vld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones_cnt <= '0;
    end else begin
      r_ones_cnt <= w_ones_nxt;
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: destuffs the line, assembles octets LSB-first and emits
// them one byte late so the closing flag can mark the last one with eof.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             flag_in,
  output logic             byte_vld,
  output logic [7:0]       byte_data,
  output logic             byte_sof,
  output logic             byte_eof,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic             abort
);

  logic w_data_vld;
  logic w_data_bit;
  logic w_flag_evt;
  logic w_abort_evt;

  hdlc_zero_destuffer u_destuff (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .flag_in      (flag_in),
    .data_bit_vld (w_data_vld),
    .data_bit     (w_data_bit),
    .flag_evt     (w_flag_evt),
    .abort_evt    (w_abort_evt)
  );

  hdlc_state_e          r_state;
  logic [BYTE_W-1:0]    r_sr;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BYTE_W-1:0]    r_hold;
  logic                 r_hold_vld;
  logic                 r_sof_pend;
  logic [LEN_W-1:0]     r_len;

  logic [BYTE_W-1:0]    w_sr_nxt;
  logic                 w_byte_done;
  logic [LEN_W-1:0]     w_len_inc;

  assign w_sr_nxt    = {w_data_bit, r_sr[BYTE_W-1:1]};
  assign w_byte_done = w_data_vld && (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  assign w_len_inc   = (r_len == {LEN_W{1'b1}}) ? r_len : (r_len + LEN_W'(1));

  // Framing FSM with registered byte/marker outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_sof_pend <= 1'b1;
      r_len      <= '0;
      byte_vld   <= 1'b0;
      byte_data  <= '0;
      byte_sof   <= 1'b0;
      byte_eof   <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      byte_data <= '0;
      byte_sof  <= 1'b0;
      byte_eof  <= 1'b0;
      frame_len <= '0;
      frame_err <= 1'b0;
      abort     <= 1'b0;
      if (w_data_vld) begin
        r_sr <= w_sr_nxt;
      end
      case (r_state)
        HUNT: begin
          r_bit_cnt <= '0;
          if (w_flag_evt) begin
            r_state <= OPEN;
          end
        end
        OPEN: begin
          if (w_flag_evt) begin
            r_bit_cnt <= '0;
          end else if (w_abort_evt) begin
            r_bit_cnt <= '0;
            r_state   <= HUNT;
          end else if (w_byte_done) begin
            r_hold     <= w_sr_nxt;
            r_hold_vld <= 1'b1;
            r_bit_cnt  <= '0;
            r_state    <= DATA;
          end else if (w_data_vld) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          if (w_flag_evt) begin
            // Closing flag: held byte is the last one; misalignment is flagged alongside it
            byte_vld   <= r_hold_vld;
            byte_data  <= r_hold;
            byte_sof   <= r_sof_pend;
            byte_eof   <= 1'b1;
            frame_len  <= w_len_inc;
            frame_err  <= (r_bit_cnt != BIT_CNT_W'(FLAG_TAIL_BITS));
            r_hold_vld <= 1'b0;
            r_sof_pend <= 1'b1;
            r_len      <= '0;
            r_bit_cnt  <= '0;
            r_state    <= OPEN;
          end else if (w_abort_evt) begin
            abort      <= 1'b1;
            r_hold_vld <= 1'b0;
            r_sof_pend <= 1'b1;
            r_len      <= '0;
            r_bit_cnt  <= '0;
            r_state    <= HUNT;
          end else if (w_byte_done) begin
            byte_vld   <= r_hold_vld;
            byte_data  <= r_hold;
            byte_sof   <= r_sof_pend;
            r_hold     <= w_sr_nxt;
            r_sof_pend <= 1'b0;
            r_len      <= w_len_inc;
            r_bit_cnt  <= '0;
          end else if (w_data_vld) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          end
        end
        default: begin
          r_state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: frame-level vector table, hand sequences for aborts,
// shared flags and reset, and random line traffic against a queue-based model.
`timescale 1ns/1ps
module tb_hdlc_rx_deframer;
  import hdlc_pkg::*;

  localparam int unsigned TB_LEN_W = 3;
  localparam int          LEN_MAX  = (1 << TB_LEN_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                bit_in;
  logic                flag_in;
  logic                byte_vld;
  logic [7:0]          byte_data;
  logic                byte_sof;
  logic                byte_eof;
  logic [TB_LEN_W-1:0] frame_len;
  logic                frame_err;
  logic                abort;

  hdlc_rx_deframer #(.LEN_W(TB_LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .flag_in   (flag_in),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .byte_sof  (byte_sof),
    .byte_eof  (byte_eof),
    .frame_len (frame_len),
    .frame_err (frame_err),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                vld;
    logic [7:0]          data;
    logic                sof;
    logic                eof;
    logic [TB_LEN_W-1:0] len;
    logic                err;
    logic                abt;
  } obs_t;

  typedef struct {
    string       name;
    int          nb;
    logic [79:0] pl;
    int          extra;
    logic [7:0]  xb;
    int          exp_n;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    int          exp_len;
    int          exp_err;
  } vec_t;

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  string cur_test = "init";
  int    tx_ones = 0;
  obs_t  got_q[$];
  int    abort_cnt = 0;

  // Reference model: destuffed bits of the open frame kept in a queue
  bit    m_in = 1'b0;
  int    m_run = 0;
  bit    m_q[$];

  function automatic logic [7:0] m_byte(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_q[8*k + i];
    return v;
  endfunction

  task automatic model_step(input logic r, input logic b, input logic f, output obs_t e);
    int n;
    int nb;
    e = '0;
    if (r) begin
      m_in = 1'b0;
      m_run = 0;
      m_q.delete();
    end else if (f) begin
      n = m_q.size();
      nb = n / 8;
      if (m_in && nb > 0) begin
        e.vld  = 1'b1;
        e.data = m_byte(nb - 1);
        e.sof  = (nb == 1);
        e.eof  = 1'b1;
        e.len  = (nb > LEN_MAX) ? TB_LEN_W'(LEN_MAX) : TB_LEN_W'(nb);
        e.err  = ((n % 8) != 6);
      end
      m_in = 1'b1;
      m_q.delete();
      m_run = 0;
    end else begin
      if (m_run >= int'(ONES_FLAG)) begin
        if (m_in && (m_q.size() / 8) > 0) e.abt = 1'b1;
        m_in = 1'b0;
        m_q.delete();
      end else if (m_run != int'(ONES_STUFF) && m_in) begin
        m_q.push_back(b);
        n = m_q.size();
        if ((n % 8) == 0 && n >= 16) begin
          e.vld  = 1'b1;
          e.data = m_byte(n / 8 - 2);
          e.sof  = (n == 16);
        end
      end
      m_run = b ? m_run + 1 : 0;
    end
  endtask

  // One line bit: drive, advance a clock, compare the registered response
  task automatic step(input logic r, input logic b, input logic f);
    obs_t e;
    obs_t g;
    logic bad;
    rst = r;
    bit_in = b;
    flag_in = f;
    model_step(r, b, f, e);
    @(posedge clk);
    #1;
    cyc++;
    g = {byte_vld, byte_data, byte_sof, byte_eof, frame_len, frame_err, abort};
    bad = (g.vld != e.vld) || (g.err != e.err) || (g.abt != e.abt);
    if (e.vld) bad = bad || (g.data != e.data) || (g.sof != e.sof) || (g.eof != e.eof);
    if (e.eof) bad = bad || (g.len != e.len);
    if (r) bad = bad || (g != obs_t'(0));
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got {vld,data,sof,eof,len,err,abt}=%h, expected %h",
               cur_test, cyc, g, e);
    end
    if (g.vld) got_q.push_back(g);
    if (g.abt) abort_cnt++;
  endtask

  task automatic expect_int(input string what, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d (0x%0h), expected %0d (0x%0h)", cur_test, what, got, got, exp, exp);
    end
  endtask

  task automatic send_flag();
    logic [7:0] fl;
    fl = HDLC_FLAG;
    for (int i = 0; i < 8; i++) step(1'b0, fl[i], (i == 7));
    tx_ones = 0;
  endtask

  task automatic send_data_bit(input logic b);
    step(1'b0, b, 1'b0);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 5) begin
      step(1'b0, 1'b0, 1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic send_raw(input logic b);
    step(1'b0, b, 1'b0);
    tx_ones = 0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    tx_ones = 0;
  endtask

  task automatic clear_log(input string name);
    cur_test = name;
    got_q.delete();
    abort_cnt = 0;
  endtask

  task automatic check_rec(input int idx, input logic [7:0] d, input int sof, input int eof,
                           input int len, input int err);
    if (idx < got_q.size()) begin
      expect_int($sformatf("b%0d_data", idx), got_q[idx].data, d);
      expect_int($sformatf("b%0d_sof", idx), got_q[idx].sof, sof);
      expect_int($sformatf("b%0d_eof", idx), got_q[idx].eof, eof);
      if (eof != 0) expect_int($sformatf("b%0d_len", idx), got_q[idx].len, len);
      expect_int($sformatf("b%0d_err", idx), got_q[idx].err, err);
    end
  endtask

  task automatic run_vec(input vec_t v);
    clear_log(v.name);
    send_flag();
    for (int i = 0; i < v.nb; i++) send_byte(v.pl[8*i +: 8]);
    for (int i = 0; i < v.extra; i++) send_data_bit(v.xb[i]);
    send_flag();
    expect_int("n_bytes", got_q.size(), v.exp_n);
    if (got_q.size() > 0) begin
      expect_int("first_data", got_q[0].data, v.exp_first);
      expect_int("first_sof", got_q[0].sof, 1);
      expect_int("last_data", got_q[got_q.size()-1].data, v.exp_last);
      expect_int("last_eof", got_q[got_q.size()-1].eof, 1);
      expect_int("last_len", got_q[got_q.size()-1].len, v.exp_len);
      expect_int("last_err", got_q[got_q.size()-1].err, v.exp_err);
    end
    expect_int("aborts", abort_cnt, 0);
  endtask

  function automatic vec_t mk(input string name, input int nb, input logic [79:0] pl,
                              input int extra, input logic [7:0] xb, input int exp_n,
                              input logic [7:0] ef, input logic [7:0] el,
                              input int elen, input int eerr);
    vec_t v;
    v.name = name; v.nb = nb; v.pl = pl; v.extra = extra; v.xb = xb;
    v.exp_n = exp_n; v.exp_first = ef; v.exp_last = el; v.exp_len = elen; v.exp_err = eerr;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    int sel;
    int nb;
    tbl[0] = mk("a5_3c",     2, 80'h3CA5,               0, 8'h00, 2, 8'hA5, 8'h3C, 2, 0);
    tbl[1] = mk("stuff_1f_ff", 2, 80'hFF1F,             0, 8'h00, 2, 8'h1F, 8'hFF, 2, 0);
    tbl[2] = mk("single_55", 1, 80'h55,                 0, 8'h00, 1, 8'h55, 8'h55, 1, 0);
    tbl[3] = mk("err_1bit",  1, 80'h12,                 1, 8'h01, 1, 8'h12, 8'h12, 1, 1);
    tbl[4] = mk("err_3bit",  1, 80'h12,                 3, 8'h05, 2, 8'h12, 8'hF5, 2, 1);
    tbl[5] = mk("data_7e",   3, 80'hFF7E00,             0, 8'h00, 3, 8'h00, 8'hFF, 3, 0);
    tbl[6] = mk("len_sat",   9, 80'h090807060504030201, 0, 8'h00, 9, 8'h01, 8'h09, 7, 0);

    rst = 1'b1;
    bit_in = 1'b0;
    flag_in = 1'b0;
    cur_test = "reset";
    do_reset(2);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Abort inside DATA, then data while hunting is ignored until a flag
    clear_log("abort");
    send_flag();
    send_byte(8'h12);
    repeat (8) send_raw(1'b1);
    expect_int("n_bytes_after_abort", got_q.size(), 0);
    expect_int("aborts", abort_cnt, 1);
    send_byte(8'h33);
    send_flag();
    expect_int("n_bytes_hunt", got_q.size(), 0);
    send_byte(8'h55);
    send_flag();
    expect_int("n_bytes_recover", got_q.size(), 1);
    check_rec(0, 8'h55, 1, 1, 1, 0);
    expect_int("aborts_final", abort_cnt, 1);

    // Idle flags followed by two frames sharing a flag
    clear_log("shared_flag");
    repeat (3) send_flag();
    send_byte(8'h01);
    send_flag();
    send_byte(8'h02);
    send_flag();
    expect_int("n_bytes", got_q.size(), 2);
    check_rec(0, 8'h01, 1, 1, 1, 0);
    check_rec(1, 8'h02, 1, 1, 1, 0);

    // Reset in the middle of a frame
    clear_log("mid_reset");
    send_flag();
    send_byte(8'hC3);
    send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1); send_data_bit(1'b0);
    do_reset(1);
    expect_int("n_bytes_lost", got_q.size(), 0);
    send_flag();
    send_byte(8'hC3);
    send_flag();
    expect_int("n_bytes", got_q.size(), 1);
    check_rec(0, 8'hC3, 1, 1, 1, 0);
    expect_int("aborts", abort_cnt, 0);

    // Random line traffic checked cycle by cycle against the model
    cur_test = "random";
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: do_reset(int'($urandom_range(1, 2)));
        1: repeat ($urandom_range(7, 12)) send_raw(1'b1);
        2: repeat ($urandom_range(1, 20)) send_raw(1'($urandom_range(0, 1)));
        3: send_flag();
        default: begin
          send_flag();
          nb = int'($urandom_range(0, 6));
          for (int i = 0; i < nb; i++) send_byte(8'($urandom));
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 7)) send_data_bit(1'($urandom_range(0, 1)));
          send_flag();
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
